// File: rtl/lifo_stack_resp.sv
// lifo_stack_resp: LIFO stack responder for the DUT end of the LIFO VIP interface.
// Pushes go in via data_wr/wr_en and pops come out via rd_en. Pop data is registered
// on data_rd. Full/empty status, occupancy and one-cycle overflow/underflow pulses are
// reported every cycle.
// Build option: define LIFO_BYPASS_EN to forward data_wr straight to data_rd on a
// simultaneous push+pop into an empty stack. In that case nothing is stored and no
// error is raised.
module lifo_stack_resp #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_wr,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_rd,
  output logic                  lifo_full,
  output logic                  lifo_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          push_ok;
  logic          pop_ok;
  logic          swap;
  logic          empty_both;
  logic          wr_err_d;
  logic          rd_err_d;

  // Status flags decode only from the registered count, so they are glitch-free
  always_comb begin
    lifo_full  = (count == CNT_W'(DEPTH));
    lifo_empty = (count == '0);
  end

  // Classify the request for this cycle and derive the indices of the top and next-free slots
  always_comb begin
    top_idx    = AW'(count - CNT_W'(1));
    wr_idx     = AW'(count);
    push_ok    = wr_en && !rd_en && !lifo_full;
    pop_ok     = rd_en && !wr_en && !lifo_empty;
    swap       = wr_en && rd_en && !lifo_empty;
    empty_both = wr_en && rd_en && lifo_empty;
    wr_err_d   = wr_en && !rd_en && lifo_full;
`ifdef LIFO_BYPASS_EN
    rd_err_d   = rd_en && !wr_en && lifo_empty;
`else
    rd_err_d   = rd_en && lifo_empty;
`endif
  end

  // Storage write port. The array is not reset. A swap overwrites the current top
  // entry in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (push_ok)
        mem[wr_idx] <= data_wr;
      else if (swap)
        mem[top_idx] <= data_wr;
`ifndef LIFO_BYPASS_EN
      else if (empty_both)
        mem[wr_idx] <= data_wr;
`endif
    end
  end

  // Occupancy, registered pop data and error pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      data_rd <= '0;
      wr_err  <= 1'b0;
      rd_err  <= 1'b0;
    end else begin
      wr_err <= wr_err_d;
      rd_err <= rd_err_d;
      if (push_ok) begin
        count <= count + CNT_W'(1);
      end else if (pop_ok) begin
        data_rd <= mem[top_idx];
        count   <= count - CNT_W'(1);
      end else if (swap) begin
        data_rd <= mem[top_idx];
      end else if (empty_both) begin
`ifdef LIFO_BYPASS_EN
        data_rd <= data_wr;
`else
        count <= CNT_W'(1);
`endif
      end
    end
  end

endmodule

// File: doc/lifo_stack_resp.md
Name: lifo_stack_resp

Overview:
- Synthesizable LIFO (stack) responder that sits at the DUT end of the LIFO VIP interface.
- Accepts pushes via data_wr/wr_en and pops via rd_en.
- Returns registered pop data on data_rd and reports full/empty status every cycle.
- Adds occupancy and error pulses so the VIP monitor and scoreboard can check overflow and underflow handling directly.

Parameters:
- DEPTH, 12, number of stack entries (>=2).
- DATA_WIDTH, 8, width of data_wr/data_rd.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low.
- data_wr  input  DATA_WIDTH  push data, sampled when wr_en=1.
- wr_en  input  1  push request, one push per cycle.
- rd_en  input  1  pop request, one pop per cycle.
- data_rd  output  DATA_WIDTH  registered pop data.
- lifo_full  output  1  count==DEPTH.
- lifo_empty  output  1  count==0.
- count  output  CNT_W  current occupancy.
- wr_err  output  1  one-cycle pulse: push dropped (full, no pop).
- rd_err  output  1  one-cycle pulse: pop on empty.

Behaviour:
- Reset: clock and reset are single-clock; reset is asynchronous, active-low (rst=0 resets).
  - On reset: count=0, top pointer=0, data_rd=0, lifo_empty=1, lifo_full=0, wr_err=0, rd_err=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries immediately, with no pending pop output.
- State: storage array mem[DEPTH] plus count register. The top entry is mem[count-1]. lifo_full and lifo_empty decode combinationally from registered count only, so they are glitch-free and valid the cycle after the causing edge.
- Push only (wr_en=1, rd_en=0):
  - Not full: mem[count]<=data_wr, count+1.
  - Full: write dropped, count unchanged, wr_err=1 for one cycle.
- Pop only (wr_en=0, rd_en=1):
  - Not empty: data_rd<=mem[count-1], count-1. Latency: data_rd is valid the cycle after the rd_en sampling edge.
  - Empty: data_rd holds its previous value, count stays 0, rd_err=1 for one cycle.
- Push and pop in the same cycle:
  - Not empty (including full): data_rd<=mem[count-1] (old top), mem[count-1]<=data_wr (replace top), count unchanged, no error.
  - Empty (macro off): push accepted, count becomes 1, pop ignored, rd_err=1, data_rd holds.
- Idle: data_rd holds the last popped value indefinitely; nothing changes.
- Width rule: count never exceeds DEPTH and never underflows below 0. Index arithmetic uses CNT_W bits with no wrap-around; the saturation checks above guarantee this.
- wr_err/rd_err are registered pulses, deasserted every cycle their condition is absent.

Optional Feature:
- Macro: LIFO_BYPASS_EN.
- Defined: simultaneous wr_en and rd_en while empty forwards the data, with no error.
  - data_rd<=data_wr the next cycle.
  - count stays 0, memory is not written, rd_err=0.
- Undefined: empty-cycle push+pop behaves as in Behaviour (push stored, rd_err pulse).
- All other behaviour is identical in both builds.

Test Plan (DEPTH=4, DATA_WIDTH=8):
1. Reset then idle. Hold rst=0 for 3 cycles with wr_en=1 and data 0xAA, then release → lifo_empty=1, lifo_full=0, count=0, data_rd=0x00, no err pulses.
2. Fill and overflow. Push 0x11,0x22,0x33,0x44 then push 0x55 → count steps 1..4, lifo_full=1 after the 4th push, wr_err pulses once on the 5th push, count stays 4.
3. LIFO order and underflow. From the full stack, pop 5 times → data_rd=0x44,0x33,0x22,0x11, each one cycle after its rd_en. lifo_empty=1 after the 4th pop. The 5th pop gives rd_err=1 and data_rd holds 0x11.
4. Simultaneous push+pop mid-stack. Stack [0x11,0x22], drive wr_en=rd_en=1 with data 0x99, then pop twice → data_rd=0x22 then 0x99 then 0x11; count stays 2 across the simultaneous cycle.
5. Simultaneous push+pop when full. Stack full 0x11..0x44, push+pop 0x77 → data_rd=0x44, count=4, no wr_err; the next pop returns 0x77.
6. Empty push+pop with data 0x5A:
   - Macro off → count=1, rd_err=1, data_rd unchanged; the next pop returns 0x5A.
   - With LIFO_BYPASS_EN → data_rd=0x5A next cycle, count=0, no errors.
